// File: rtl/aes_pkg.sv
// Shared AES byte constants, S-box tables and the substitution FSM state type.
// The forward table only exists when INV_SUB_BYTES_FWD_EN is defined.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX_TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [AES_BYTE_W-1:0] inv_sbox_f(input logic [AES_BYTE_W-1:0] b);
        return INV_SBOX_TBL[b];
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [AES_BYTE_W-1:0] sbox_f(input logic [AES_BYTE_W-1:0] b);
        return SBOX_TBL[b];
    endfunction
`endif

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// One-byte combinational S-box lookup; inverse only, or direction-selectable
// when INV_SUB_BYTES_FWD_EN is defined (dir=1 forward, dir=0 inverse).
module inv_sbox
    import aes_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic                  dir,
`endif
    input  logic [AES_BYTE_W-1:0] data,
    output logic [AES_BYTE_W-1:0] subst
);

`ifdef INV_SUB_BYTES_FWD_EN
    assign subst = dir ? sbox_f(data) : inv_sbox_f(data);
`else
    assign subst = inv_sbox_f(data);
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: LANES bytes per cycle through a rotate-substitute shift register.
// INV_SUB_BYTES_FWD_EN adds a per-block dir input selecting the forward S-box.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int LANES = 4
) (
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic             dir,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int NBYTES = WIDTH / AES_BYTE_W;
    localparam int NSTEP  = NBYTES / LANES;
    localparam int CNT_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int LANE_W = AES_BYTE_W * LANES;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    generate
        if ((WIDTH % AES_BYTE_W) != 0 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_params
            $error("inv_sub_bytes_seq: WIDTH must be a multiple of 8 and LANES must divide WIDTH/8");
        end
    endgenerate

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;
    logic [LANE_W-1:0] subst_bytes;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             idle_reg;
    logic             load;
`ifdef INV_SUB_BYTES_FWD_EN
    logic             dir_reg;
`endif

    // DONE hands in_ready straight through from out_ready so a new block can
    // be taken on the same edge the finished one leaves.
    assign in_ready  = idle_reg | (out_valid_reg & out_ready);
    assign load      = in_valid & in_ready;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_data  = sr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            inv_sbox u_sbox (
`ifdef INV_SUB_BYTES_FWD_EN
                .dir   (dir_reg),
`endif
                .data  (sr_reg[WIDTH-1-AES_BYTE_W*gi -: AES_BYTE_W]),
                .subst (subst_bytes[LANE_W-1-AES_BYTE_W*gi -: AES_BYTE_W])
            );
        end

        // Substituted top lanes re-enter at the bottom; after NSTEP steps the
        // whole register has rotated once and every byte is home again.
        if (LANE_W == WIDTH) begin : g_rot_full
            assign sr_next = subst_bytes;
        end else begin : g_rot_part
            assign sr_next = {sr_reg[WIDTH-LANE_W-1:0], subst_bytes};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sr_reg        <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            idle_reg      <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
            dir_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        sr_reg    <= in_data;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                        idle_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
                        dir_reg   <= dir;
`endif
                    end
                end
                ST_RUN: begin
                    sr_reg <= sr_next;
                    if (cnt_reg == LAST_STEP) begin
                        cnt_reg       <= '0;
                        state_reg     <= ST_DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            sr_reg    <= in_data;
                            cnt_reg   <= '0;
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
                            dir_reg   <= dir;
`endif
                        end else begin
                            state_reg <= ST_IDLE;
                            idle_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    idle_reg      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq; expected bytes come from hand constants and
// a GF(2^8) forward S-box model. Define INV_SUB_BYTES_FWD_EN to exercise dir.
module tb_inv_sub_bytes_seq;

    localparam int WIDTH = 256;
    localparam int NVEC  = 10;

    typedef struct {
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef INV_SUB_BYTES_FWD_EN
    logic             dir;
`endif

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;

    vec_t       vecs [NVEC];
    logic [7:0] fwd  [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.WIDTH(WIDTH), .LANES(4)) dut (
`ifdef INV_SUB_BYTES_FWD_EN
        .dir       (dir),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents din and returns just after the edge that accepted it.
    task automatic accept_block(input string name, input logic [WIDTH-1:0] din);
        int n = 0;
        in_data  = din;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk({name, " accept_timeout"}, 0, 1);
        tick();
        in_valid = 1'b0;
        chk({name, " busy_in_run"}, busy, 1);
        chk({name, " in_ready_in_run"}, in_ready, 0);
    endtask

    // Waits for out_valid, checks latency and data; leaves the block unconsumed.
    task automatic wait_out(input string name, input logic [WIDTH-1:0] want);
        int cyc = 0;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, WIDTH'(cyc), WIDTH'(8));
        chk({name, " data"}, out_data, want);
        $display("xfer %s latency=%0d data=%h", name, cyc, out_data);
    endtask

    task automatic run_block(input string name, input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] want);
        out_ready = 1'b1;
        accept_block(name, din);
        wait_out(name, want);
        tick();
    endtask

    initial begin
        logic [7:0]       pin  [4];
        logic [7:0]       pout [4];
        logic [WIDTH-1:0] sin  [3];
        logic [WIDTH-1:0] sexp [3];
        int               acc_t [3];
        int               n_acc;
        int               n_out;
        int               x0;
        logic             acc;
        logic             ox;
        logic [WIDTH-1:0] od;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
        dir       = 1'b0;
`endif

        for (int i = 0; i < 256; i++) fwd[i] = sbox_model(8'(i));

        // vector 0: all 0x63 -> all 0x00
        vecs[0].din = {32{8'h63}};
        vecs[0].exp = '0;
        // vector 1: 00,16,7c,52 pattern -> 52,ff,01,48
        pin  = '{8'h00, 8'h16, 8'h7c, 8'h52};
        pout = '{8'h52, 8'hff, 8'h01, 8'h48};
        for (int i = 0; i < 32; i++) begin
            vecs[1].din[WIDTH-1-8*i -: 8] = pin[i % 4];
            vecs[1].exp[WIDTH-1-8*i -: 8] = pout[i % 4];
        end
        // vectors 2..9: S(v) for every v, so each output byte must come back as v
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 32; i++) begin
                vecs[2+b].din[WIDTH-1-8*i -: 8] = fwd[b*32 + i];
                vecs[2+b].exp[WIDTH-1-8*i -: 8] = 8'(b*32 + i);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", out_data, 0);

        for (int v = 0; v < NVEC; v++) begin
            run_block($sformatf("vec%0d", v), vecs[v].din, vecs[v].exp);
        end

        // Backpressure: hold five cycles, then exactly one transfer.
        out_ready = 1'b0;
        accept_block("hold", vecs[3].din);
        wait_out("hold", vecs[3].exp);
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold%0d out_valid", i), out_valid, 1);
            chk($sformatf("hold%0d out_data", i), out_data, vecs[3].exp);
            chk($sformatf("hold%0d in_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("hold release in_ready", in_ready, 1);
        tick();
        chk("hold after out_valid", out_valid, 0);
        chk("hold after in_ready", in_ready, 1);
        repeat (3) tick();
        chk("hold xfer count", WIDTH'(xfer_cnt - x0), WIDTH'(1));
        $display("xfer hold transfers=%0d", xfer_cnt - x0);

        // Streaming: in_valid held high, out_ready=1.
        sin[0] = vecs[4].din; sexp[0] = vecs[4].exp;
        sin[1] = vecs[1].din; sexp[1] = vecs[1].exp;
        sin[2] = vecs[7].din; sexp[2] = vecs[7].exp;
        n_acc = 0;
        n_out = 0;
        in_data  = sin[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && n_out < 3; cyc++) begin
            acc = in_valid && in_ready;
            ox  = out_valid && out_ready;
            od  = out_data;
            tick();
            if (ox) begin
                chk($sformatf("stream out%0d", n_out), od, sexp[n_out]);
                $display("xfer stream%0d data=%h", n_out, od);
                n_out++;
            end
            if (acc && n_acc < 3) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) in_data = sin[n_acc];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream outputs", WIDTH'(n_out), WIDTH'(3));
        chk("stream accepts", WIDTH'(n_acc), WIDTH'(3));
        if (n_acc == 3) begin
            chk("stream gap01", WIDTH'(acc_t[1] - acc_t[0]), WIDTH'(9));
            chk("stream gap12", WIDTH'(acc_t[2] - acc_t[1]), WIDTH'(9));
        end
        tick();

        // Reset at RUN step 3 discards the block.
        accept_block("rst", vecs[5].din);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst out_data", out_data, 0);
        run_block("post_rst", vecs[1].din, vecs[1].exp);

`ifdef INV_SUB_BYTES_FWD_EN
        dir = 1'b1;
        run_block("fwd_zero", '0, {32{8'h63}});
        dir = 1'b1;
        out_ready = 1'b1;
        accept_block("fwd_flip", vecs[1].exp);
        dir = 1'b0;
        wait_out("fwd_flip", vecs[1].din);
        tick();
        dir = 1'b0;
        run_block("inv_after_fwd", vecs[0].din, vecs[0].exp);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
